// File: rtl/uart_rx_buffer_if.sv
// Receiver-to-consumer bus of the UART receive buffer: push side from the
// receiver, pop side and status toward the consumer.
interface uart_rx_buffer_if #(
  parameter int DEPTH_LOG2 = 4
);
  // Strobe semantics: i_store_req and i_load_req are single-cycle requests
  // sampled on the rising clock; a push is accepted when the buffer has room
  // (or pops in the same cycle), a pop only when o_valid is high. Requests that
  // cannot be honoured are dropped, never held off, so there is no ready.
  logic                  i_store_req;
  logic [15:0]           i_data;
  logic                  i_error_parity;
  logic                  i_error_stop_bit;
  logic                  i_load_req;
  logic                  i_clear_flags;
  logic [15:0]           o_data;
  logic                  o_error_parity;
  logic                  o_valid;
  logic                  o_full;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_overrun;
  logic                  o_error_frame;
  logic                  o_timeout;

  modport master (
    output i_store_req, i_data, i_error_parity, i_error_stop_bit,
           i_load_req, i_clear_flags,
    input  o_data, o_error_parity, o_valid, o_full, o_count,
           o_overrun, o_error_frame, o_timeout
  );

  modport slave (
    input  i_store_req, i_data, i_error_parity, i_error_stop_bit,
           i_load_req, i_clear_flags,
    output o_data, o_error_parity, o_valid, o_full, o_count,
           o_overrun, o_error_frame, o_timeout
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// First-word-fall-through receive FIFO for a UART: stores words with their
// parity flag, tracks sticky overrun/framing errors and an idle timeout.
module uart_rx_buffer #(
  parameter int DEPTH_LOG2     = 4,
  parameter int TIMEOUT_CYCLES = 320
) (
  input  logic             i_clock_x8,
  input  logic             i_reset_n,
  uart_rx_buffer_if.slave  bus
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_COUNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [IDLE_W-1:0]   IDLE_MAX   = IDLE_W'(TIMEOUT_CYCLES);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  logic [16:0]         mem [DEPTH];
  ptr_t                wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [DEPTH_LOG2:0] count, count_nxt;
  logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
  logic [16:0]         head_q, head_nxt;
  logic                valid_q, full_q, overrun_q, frame_q, timeout_q;
  logic                overrun_nxt, frame_nxt, timeout_nxt;
  logic                do_push, do_pop, is_empty, is_full;

  always_comb begin
    is_empty    = (count == '0);
    is_full     = (count == FULL_COUNT);
    do_pop      = bus.i_load_req && !is_empty;
    do_push     = bus.i_store_req && (!is_full || do_pop);

    wr_ptr_nxt  = do_push ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_nxt  = do_pop  ? rd_ptr + 1'b1 : rd_ptr;

    count_nxt   = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase

    // The word being written becomes the head only when it is the sole entry
    // afterwards; it is not in the array yet, so bypass it.
    head_nxt = head_q;
    if (count_nxt != '0) begin
      if (do_push && count_nxt == ONE_COUNT)
        head_nxt = {bus.i_error_parity, bus.i_data};
      else
        head_nxt = mem[rd_ptr_nxt];
    end

    // Sticky flags: a new event in the same cycle beats the clear.
    overrun_nxt = overrun_q;
    if (bus.i_store_req && !do_push)
      overrun_nxt = 1'b1;
    else if (bus.i_clear_flags)
      overrun_nxt = 1'b0;

    frame_nxt = frame_q;
    if (bus.i_error_stop_bit)
      frame_nxt = 1'b1;
    else if (bus.i_clear_flags)
      frame_nxt = 1'b0;

    idle_nxt = idle_cnt;
    if (do_push || do_pop || is_empty)
      idle_nxt = '0;
    else if (idle_cnt != IDLE_MAX)
      idle_nxt = idle_cnt + 1'b1;

    timeout_nxt = (idle_nxt == IDLE_MAX) && (count_nxt != '0);
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge i_clock_x8) begin
    if (do_push)
      mem[wr_ptr] <= {bus.i_error_parity, bus.i_data};
  end

  always_ff @(posedge i_clock_x8 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      idle_cnt  <= '0;
      head_q    <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      idle_cnt  <= idle_nxt;
      head_q    <= head_nxt;
      valid_q   <= (count_nxt != '0);
      full_q    <= (count_nxt == FULL_COUNT);
      overrun_q <= overrun_nxt;
      frame_q   <= frame_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign bus.o_data         = head_q[15:0];
  assign bus.o_error_parity = head_q[16];
  assign bus.o_valid        = valid_q;
  assign bus.o_full         = full_q;
  assign bus.o_count        = count;
  assign bus.o_overrun      = overrun_q;
  assign bus.o_error_frame  = frame_q;
  assign bus.o_timeout      = timeout_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the receive buffer.
module tb_uart_rx_buffer;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int TIMEOUT    = 320;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  uart_rx_buffer_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_rx_buffer #(.DEPTH_LOG2(DEPTH_LOG2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clock_x8 (clk),
    .i_reset_n  (rst_n),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [16:0] m_q[$];
  logic [16:0] m_last = '0;
  int          m_idle = 0;
  bit          m_ovr  = 1'b0;
  bit          m_frm  = 1'b0;

  always @(negedge rst_n) begin
    m_q.delete();
    m_last = '0;
    m_idle = 0;
    m_ovr  = 1'b0;
    m_frm  = 1'b0;
  end

  always @(posedge clk) begin
    bit pop, push;
    if (rst_n) begin
      pop  = bus.i_load_req && (m_q.size() > 0);
      push = bus.i_store_req && ((m_q.size() < DEPTH) || pop);
      if (bus.i_store_req && !push) m_ovr = 1'b1;
      else if (bus.i_clear_flags)   m_ovr = 1'b0;
      if (bus.i_error_stop_bit)     m_frm = 1'b1;
      else if (bus.i_clear_flags)   m_frm = 1'b0;
      if (push || pop || m_q.size() == 0) m_idle = 0;
      else if (m_idle < TIMEOUT)         m_idle = m_idle + 1;
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back({bus.i_error_parity, bus.i_data});
      if (m_q.size() > 0) m_last = m_q[0];
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid",   32'(bus.o_valid),        32'(m_q.size() > 0));
      chk("count",   32'(bus.o_count),        32'(m_q.size()));
      chk("full",    32'(bus.o_full),         32'(m_q.size() == DEPTH));
      chk("data",    32'(bus.o_data),         32'(m_last[15:0]));
      chk("parity",  32'(bus.o_error_parity), 32'(m_last[16]));
      chk("overrun", 32'(bus.o_overrun),      32'(m_ovr));
      chk("frame",   32'(bus.o_error_frame),  32'(m_frm));
      chk("timeout", 32'(bus.o_timeout),      32'(m_idle == TIMEOUT && m_q.size() > 0));
    end
  end

  // ---------------- driver ----------------
  // Called just after a falling edge; returns at the next falling edge.
  task automatic tick(input logic st, input logic [15:0] d, input logic par,
                      input logic stop, input logic ld, input logic clr);
    bus.i_store_req      = st;
    bus.i_data           = d;
    bus.i_error_parity   = par;
    bus.i_error_stop_bit = stop;
    bus.i_load_req       = ld;
    bus.i_clear_flags    = clr;
    @(posedge clk);
    #1;
    bus.i_store_req      = 1'b0;
    bus.i_data           = '0;
    bus.i_error_parity   = 1'b0;
    bus.i_error_stop_bit = 1'b0;
    bus.i_load_req       = 1'b0;
    bus.i_clear_flags    = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d, input logic par);
    tick(1'b1, d, par, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4 && m_q.size() > 0; i++) pop();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.i_store_req      = 1'b0;
    bus.i_data           = '0;
    bus.i_error_parity   = 1'b0;
    bus.i_error_stop_bit = 1'b0;
    bus.i_load_req       = 1'b0;
    bus.i_clear_flags    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_data",  32'(bus.o_data),  32'd0);
    chk("rst_flags", 32'({bus.o_full, bus.o_overrun, bus.o_error_frame, bus.o_timeout}), 32'd0);
    rst_n = 1'b1;

    // first-word fall-through with parity flag
    push(16'h00A5, 1'b1);
    chk("fwft_valid",  32'(bus.o_valid),        32'd1);
    chk("fwft_data",   32'(bus.o_data),         32'h00A5);
    chk("fwft_parity", 32'(bus.o_error_parity), 32'd1);
    push(16'h1234, 1'b0);
    chk("fwft_count2", 32'(bus.o_count),        32'd2);
    pop();
    chk("pop_data",    32'(bus.o_data),         32'h1234);
    chk("pop_parity",  32'(bus.o_error_parity), 32'd0);
    chk("pop_count",   32'(bus.o_count),        32'd1);
    pop();
    chk("empty_valid", 32'(bus.o_valid),        32'd0);
    chk("empty_hold",  32'(bus.o_data),         32'h1234);

    // overflow: 17th word dropped
    for (int i = 1; i <= 17; i++) push(16'h1000 + 16'(i), 1'b0);
    chk("ovf_full",    32'(bus.o_full),    32'd1);
    chk("ovf_count",   32'(bus.o_count),   32'd16);
    chk("ovf_overrun", 32'(bus.o_overrun), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      chk("ovf_order", 32'(bus.o_data), 32'h1000 + 32'(i));
      pop();
    end
    chk("ovf_drained", 32'(bus.o_valid), 32'd0);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(bus.o_overrun), 32'd0);

    // full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 16; i++) push(16'h2000 + 16'(i), 1'b0);
    for (int k = 0; k < 20; k++) begin
      chk("wrap_head", 32'(bus.o_data), (k < 16) ? 32'h2000 + 32'(k) : 32'h3000 + 32'(k - 16));
      tick(1'b1, 16'h3000 + 16'(k), 1'b0, 1'b0, 1'b1, 1'b0);
      chk("wrap_count", 32'(bus.o_count), 32'd16);
      chk("wrap_ovr",   32'(bus.o_overrun), 32'd0);
    end
    drain();

    // empty pop, framing error, clear vs set
    pop();
    chk("epop_count", 32'(bus.o_count), 32'd0);
    tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("frame_set",  32'(bus.o_error_frame), 32'd1);
    chk("frame_cnt",  32'(bus.o_count),       32'd0);
    tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("frame_win",  32'(bus.o_error_frame), 32'd1);
    tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("frame_clr",  32'(bus.o_error_frame), 32'd0);

    // random traffic in store-heavy / load-heavy / balanced phases
    for (int i = 0; i < 900; i++) begin
      int ph;
      int sp, lp;
      ph = (i / 100) % 3;
      sp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      lp = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
      tick($urandom_range(99) < sp, 16'($urandom), 1'($urandom),
           $urandom_range(15) == 0, $urandom_range(99) < lp,
           $urandom_range(15) == 0);
    end
    drain();

    // idle timeout
    push(16'h5555, 1'b0);
    idle(TIMEOUT - 1);
    chk("tmo_early", 32'(bus.o_timeout), 32'd0);
    idle(1);
    chk("tmo_set",   32'(bus.o_timeout), 32'd1);
    idle(5);
    chk("tmo_sat",   32'(bus.o_timeout), 32'd1);
    pop();
    chk("tmo_clr",   32'(bus.o_timeout), 32'd0);
    idle(1000);
    chk("tmo_empty", 32'(bus.o_timeout), 32'd0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) push(16'h7000 + 16'(i), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.o_count), 32'd0);
    chk("arst_valid", 32'(bus.o_valid), 32'd0);
    chk("arst_data",  32'({bus.o_error_parity, bus.o_data}), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    push(16'hBEEF, 1'b0);
    chk("arst_push_data",  32'(bus.o_data),  32'hBEEF);
    chk("arst_push_count", 32'(bus.o_count), 32'd1);
    pop();
    chk("arst_only_entry", 32'(bus.o_valid), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, FIFO depth of 2^DEPTH_LOG2 entries.
REQ-002 Parameter TIMEOUT_CYCLES, default 320, number of idle clocks (4 frames x 10 bits x 8) before o_timeout asserts.
REQ-003 i_clock_x8  input  1  sole clock, 8x baud, same clock as the receiver stage.
REQ-004 i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_store_req  input  1  one-cycle push strobe from the receiver.
REQ-006 i_data  input  16  received word, valid when i_store_req=1.
REQ-007 i_error_parity  input  1  parity error for the word, sampled with i_store_req.
REQ-008 i_error_stop_bit  input  1  framing-error pulse, no word stored.
REQ-009 i_load_req  input  1  pop strobe from the consumer.
REQ-010 i_clear_flags  input  1  clears the sticky flags.
REQ-011 o_data  output  16  head entry data, first-word-fall-through.
REQ-012 o_error_parity  output  1  parity flag of the head entry.
REQ-013 o_valid  output  1  FIFO non-empty, so the head is valid.
REQ-014 o_full  output  1  count == 2^DEPTH_LOG2.
REQ-015 o_count  output  DEPTH_LOG2+1  current occupancy.
REQ-016 o_overrun  output  1  sticky: a word was dropped while full.
REQ-017 o_error_frame  output  1  sticky: stop-bit error seen.
REQ-018 o_timeout  output  1  data waiting with no push/pop for TIMEOUT_CYCLES.

Function
REQ-019 Storage: 2^DEPTH_LOG2 entries of 17 bits ({parity_err, data}), write pointer, read pointer and count; pointers wrap modulo depth.
REQ-020 Push occurs on a clock where i_store_req=1 and (count < depth, or a pop happens in the same clock).
REQ-021 Pop occurs on a clock where i_load_req=1 and count > 0; i_load_req while empty is ignored with no state change.
REQ-022 Push and pop in the same clock: both take effect and count is unchanged, including when full.
REQ-023 A push while empty makes o_valid=1 and drives o_data/o_error_parity from the new entry on the next clock (1-cycle latency).
REQ-024 After a pop, the next entry appears on o_data on the following clock; o_data holds its last value when empty.
REQ-025 i_store_req while full without a pop: word dropped, pointers and count unchanged, o_overrun set.
REQ-026 i_error_stop_bit=1 sets o_error_frame and pushes nothing.
REQ-027 i_clear_flags clears o_overrun and o_error_frame; a set condition in the same clock wins over the clear.
REQ-028 Idle counter: cleared on any push, pop or empty state; otherwise increments, saturating at TIMEOUT_CYCLES.
REQ-029 o_timeout=1 while the idle counter == TIMEOUT_CYCLES and count > 0; it clears on the clock after a push or pop.
REQ-030 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-031 i_reset_n=0 asynchronously forces pointers, count, idle counter, o_data, o_error_parity, o_valid, o_full, o_overrun, o_error_frame and o_timeout to 0.
REQ-032 Reset asserted mid-operation discards all entries; the first clock after release accepts a push normally.
REQ-033 Storage array contents are not reset.

Verification
REQ-034 Push 0x00A5 with parity err=1, then 0x1234 -> next clock o_valid=1, o_data=0x00A5, o_error_parity=1; pop -> o_data=0x1234, o_count=1.
REQ-035 Push 17 words with depth 16 and no pops -> o_full=1, o_count=16, o_overrun=1, 17th word absent; pops return words 1..16 in order.
REQ-036 While full, push and pop in the same clock -> o_count stays 16, o_overrun stays 0, order preserved across pointer wrap.
REQ-037 Pop while empty -> no change, o_count=0; i_error_stop_bit pulse -> o_error_frame=1, o_count unchanged; i_clear_flags together with a new error -> flag stays 1.
REQ-038 Push 1 word, then idle 320 clocks -> o_timeout=1; pop -> o_timeout=0 on the next clock; empty FIFO idle 1000 clocks -> o_timeout stays 0.
REQ-039 Fill with 5 words, pulse i_reset_n low between clock edges -> outputs 0 immediately; after release a push of 0xBEEF is read back as the only entry.
